i2s_master_tx: RTL
==================

// Module: i2s_master_tx
// PURPOSE
//  I2S master transmitter: generates BCLK/LRCLK from the system clock and serialises
//  stereo signed samples onto DAT. Mirror of the codec-side receiver path: drives an
//  ADC-style link into in_i2s (bench stimulus) or a codec in slave mode.
//  One-entry input buffer with valid/ready handshake; one sample pair consumed per frame.
// PARAMETERS
//  DATA_WIDTH  24  bits per sample, MSB first; legal 1..SLOT_BITS-1
//  SLOT_BITS   32  BCLK periods per channel slot; frame = 2*SLOT_BITS BCLK periods
//  BCLK_DIV    4   clk cycles per BCLK half-period (>=1); BCLK period = 2*BCLK_DIV clk
// PORTS
//  clk          in   1   system clock, all logic on posedge
//  reset        in   1   synchronous, active-high
//  in_valid     in   1   sample pair present on in_left/in_right
//  in_ready     out  1   buffer empty; transfer when in_valid && in_ready
//  in_left      in   DW  signed left sample
//  in_right     in   DW  signed right sample
//  BCLK         out  1   bit clock (registered)
//  LRCLK        out  1   0 = left slot, 1 = right slot (registered)
//  DAT          out  1   serial data, changes on BCLK fall (registered)
//  frame_start  out  1   1-clk pulse on the edge the left slot begins
//  underrun     out  1   1-clk pulse when a frame starts with the buffer empty
// BEHAVIOUR
//  Reset (all registered): BCLK=0, LRCLK=1, DAT=0, frame_start=0, underrun=0,
//   div_cnt=0, bit_cnt=2*SLOT_BITS-1, buffer empty, shift regs 0; in_ready=0 while reset=1.
//  Divider: div_cnt 0..BCLK_DIV-1; at div_cnt==BCLK_DIV-1 BCLK toggles, div_cnt wraps.
//   First BCLK rise BCLK_DIV clks after reset release; first fall at 2*BCLK_DIV.
//  Fall edge (same clk edge BCLK 1->0): bit_cnt increments mod 2*SLOT_BITS;
//   LRCLK = (new bit_cnt >= SLOT_BITS); DAT updated for new position p = bit_cnt mod SLOT_BITS.
//  DAT per slot: p=0 -> 0 (I2S one-bit delay); p=1..DATA_WIDTH -> sample bit DATA_WIDTH-p;
//   p>DATA_WIDTH -> 0. Left slot uses left shift reg, right slot uses right shift reg.
//  Frame load: on fall edge where bit_cnt wraps to 0: frame_start=1;
//   buffer full -> both shift regs load buffer, buffer empties;
//   buffer empty -> underrun=1, shift regs load per CONFIGURATION.
//  Buffer: in_ready = !full && !reset. Accept sets full; no accept while full.
//   Accept and frame load in same clk with buffer empty: load does NOT see the new
//   sample -> underrun=1; sample held and emitted next frame.
//   Load with buffer full and in_valid=1: in_ready was 0, nothing accepted that cycle;
//   in_ready returns 1 on following clk.
//  Samples are transmitted unmodified (no sign extension; padding bits are 0).
//  Reset mid-frame: next edge returns every register to reset values; buffered and
//   in-flight samples discarded; sequence restarts as from power-up.
// CONFIGURATION
//  I2S_TX_HOLD_EN defined: on underrun shift regs reload the last transmitted pair
//   (repeat previous sample; 0 if none since reset).
//  I2S_TX_HOLD_EN undefined: on underrun shift regs load 0 (silence).
//  underrun pulse asserted identically in both builds.
// TESTING (DATA_WIDTH=24, SLOT_BITS=32, BCLK_DIV=2 unless noted)
//  Reset release -> BCLK first rise at clk 2, fall at clk 4 with frame_start=1, underrun=1,
//   LRCLK=0; BCLK period 4 clk, LRCLK period 256 clk, 50% duty.
//  Push L=24'h800001, R=24'h7FFFFE; sample DAT on BCLK rise -> left slot bits 1..24 =
//   800001 MSB first, right slot = 7FFFFE, all other slot bits 0; underrun=0 that frame.
//  Hold in_valid with pairs A,B,C -> in_ready low after A, one pair per frame_start,
//   output order A,B,C, no underrun until C done.
//  Present A in the exact clk of a frame load with buffer empty -> underrun=1, frame = 0
//   (HOLD off) or previous pair (HOLD on); A emitted in next frame.
//  Stop feeding after pair 24'h123456/24'hABCDEF -> underrun pulse each frame; DAT all 0
//   without I2S_TX_HOLD_EN, repeats 123456/ABCDEF with it.
//  Assert reset 1 clk mid left slot with buffer full -> next clk BCLK=0, LRCLK=1, DAT=0,
//   in_ready=0; after release buffered pair never appears, first frame underruns.

Source files
------------

// File: rtl/i2s_master_tx.sv
// I2S master transmitter: derives BCLK/LRCLK from clk and shifts out stereo samples MSB first.
// Optional I2S_TX_HOLD_EN: on underrun repeat the previous pair instead of sending silence.
module i2s_master_tx #(
  parameter int DATA_WIDTH = 24,
  parameter int SLOT_BITS  = 32,
  parameter int BCLK_DIV   = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_left,
  input  logic [DATA_WIDTH-1:0] in_right,
  output logic                  BCLK,
  output logic                  LRCLK,
  output logic                  DAT,
  output logic                  frame_start,
  output logic                  underrun
);

  localparam int CW = $clog2(2 * SLOT_BITS);
  localparam int DIVW = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
  localparam int IW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(2 * SLOT_BITS - 1);
  localparam logic [CW-1:0] SLOT_C = CW'(SLOT_BITS);
  localparam logic [CW-1:0] DW_C = CW'(DATA_WIDTH);
  localparam logic [DIVW-1:0] DIV_LAST = DIVW'(BCLK_DIV - 1);

  logic [DIVW-1:0]       div_cnt_q, div_cnt_d;
  logic [CW-1:0]         bit_cnt_q, bit_cnt_d;
  logic                  bclk_q, bclk_d;
  logic                  lrclk_q, lrclk_d;
  logic                  dat_q, dat_d;
  logic                  frame_start_q, frame_start_d;
  logic                  underrun_q, underrun_d;
  logic                  buf_full_q, buf_full_d;
  logic [DATA_WIDTH-1:0] buf_l_q, buf_l_d, buf_r_q, buf_r_d;
  logic [DATA_WIDTH-1:0] smp_l_q, smp_l_d, smp_r_q, smp_r_d;

  logic [CW-1:0]         pos;
  logic [IW-1:0]         idx;
  logic [DATA_WIDTH-1:0] slot_smp;
  logic                  fall;

  assign in_ready    = !buf_full_q && !reset;
  assign BCLK        = bclk_q;
  assign LRCLK       = lrclk_q;
  assign DAT         = dat_q;
  assign frame_start = frame_start_q;
  assign underrun    = underrun_q;

  always_comb begin
    div_cnt_d     = div_cnt_q + DIVW'(1);
    bit_cnt_d     = bit_cnt_q;
    bclk_d        = bclk_q;
    lrclk_d       = lrclk_q;
    dat_d         = dat_q;
    frame_start_d = 1'b0;
    underrun_d    = 1'b0;
    buf_full_d    = buf_full_q;
    buf_l_d       = buf_l_q;
    buf_r_d       = buf_r_q;
    smp_l_d       = smp_l_q;
    smp_r_d       = smp_r_q;
    pos           = '0;
    idx           = '0;
    slot_smp      = '0;
    fall          = 1'b0;

    if (div_cnt_q == DIV_LAST) begin
      div_cnt_d = '0;
      bclk_d    = !bclk_q;
      fall      = bclk_q;
    end

    if (fall) begin
      bit_cnt_d = (bit_cnt_q == CNT_LAST) ? '0 : bit_cnt_q + CW'(1);
      lrclk_d   = (bit_cnt_d >= SLOT_C);
      pos       = lrclk_d ? bit_cnt_d - SLOT_C : bit_cnt_d;

      if (bit_cnt_d == '0) begin
        frame_start_d = 1'b1;
        if (buf_full_q) begin
          smp_l_d    = buf_l_q;
          smp_r_d    = buf_r_q;
          buf_full_d = 1'b0;
        end else begin
          underrun_d = 1'b1;
`ifdef I2S_TX_HOLD_EN
          smp_l_d = smp_l_q;
          smp_r_d = smp_r_q;
`else
          smp_l_d = '0;
          smp_r_d = '0;
`endif
        end
      end

      // Slot position 0 is the I2S one-bit delay; sample bits follow, then zero padding.
      slot_smp = lrclk_d ? smp_r_d : smp_l_d;
      if (pos != '0 && pos <= DW_C) begin
        idx   = IW'(DW_C - pos);
        dat_d = slot_smp[idx];
      end else begin
        dat_d = 1'b0;
      end
    end

    // A sample accepted on a load edge is not seen by that load; it waits a frame.
    if (in_valid && in_ready) begin
      buf_full_d = 1'b1;
      buf_l_d    = in_left;
      buf_r_d    = in_right;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt_q     <= '0;
      bit_cnt_q     <= CNT_LAST;
      bclk_q        <= 1'b0;
      lrclk_q       <= 1'b1;
      dat_q         <= 1'b0;
      frame_start_q <= 1'b0;
      underrun_q    <= 1'b0;
      buf_full_q    <= 1'b0;
      buf_l_q       <= '0;
      buf_r_q       <= '0;
      smp_l_q       <= '0;
      smp_r_q       <= '0;
    end else begin
      div_cnt_q     <= div_cnt_d;
      bit_cnt_q     <= bit_cnt_d;
      bclk_q        <= bclk_d;
      lrclk_q       <= lrclk_d;
      dat_q         <= dat_d;
      frame_start_q <= frame_start_d;
      underrun_q    <= underrun_d;
      buf_full_q    <= buf_full_d;
      buf_l_q       <= buf_l_d;
      buf_r_q       <= buf_r_d;
      smp_l_q       <= smp_l_d;
      smp_r_q       <= smp_r_d;
    end
  end

endmodule
